key_event_gen: RTL and testbench

Sits directly downstream of the key debouncer and consumes its debounced, registered key level. Converts that level into single-cycle event pulses for the game-control logic (cursor move, stone place, menu):
- press
- short click
- long press
- auto-repeat while held
- release

One instance per physical key.

---
 rtl/key_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/key_event_gen.sv | 141 ++++++++++++++
 tb/tb_key_event_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the per-key event generators: FSM state encoding,
// default press timing, and the counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  localparam int KEY_LONG_CYCLES_DEF   = 50_000_000;
  localparam int KEY_REPEAT_CYCLES_DEF = 10_000_000;

  // Counter must hold the larger of the two terminal counts.
  function automatic int key_cnt_width(input int long_c, input int rep_c);
    int m;
    m = (long_c > rep_c) ? long_c : rep_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop level synchronizer, reset to 0. BYPASS=1 turns it into a
// plain wire for builds where the input is already in the clock domain.
module sync_2ff #(
  parameter int WIDTH  = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (BYPASS) begin : g_bypass
    logic unused_s;
    assign unused_s = &{1'b0, clk_i, rst_ni};
    assign q_o      = d_i;
  end else begin : g_sync
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= d_i;
        sync_q <= meta_q;
      end
    end

    assign q_o = sync_q;
  end

endmodule

// File: rtl/key_event_gen.sv
// Turns a debounced key level into press/click/long/repeat/release pulses.
// Optional build macro KEY_EVENT_SYNC_EN adds a 2-flop input synchronizer.
module key_event_gen
  import key_pkg::*;
#(
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int              CNT_W     = key_cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam bit              REPEAT_EN = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

`ifdef KEY_EVENT_SYNC_EN
  localparam bit SYNC_BYPASS = 1'b0;
`else
  localparam bit SYNC_BYPASS = 1'b1;
`endif

  logic       key_s;
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_d, click_d, long_d, repeat_d, release_d, held_d;
  logic press_q, click_q, long_q, repeat_q, release_q, held_q;

  sync_2ff #(
    .WIDTH  (1),
    .BYPASS (SYNC_BYPASS)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (key_in),
    .q_o    (key_s)
  );

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      held_q    <= held_d;
    end
  end

  // Next state and counter; release takes priority over terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = key_s ? PRESSED : IDLE;
        cnt_d   = '0;
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!REPEAT_EN || (cnt_q == REP_LAST)) begin
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse decisions, registered on the same edge as the transition
  always_comb begin
    press_d   = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    held_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        press_d = key_s;
      end
      PRESSED: begin
        click_d   = !key_s;
        release_d = !key_s;
        long_d    = key_s && (cnt_q == LONG_LAST);
      end
      HELD: begin
        release_d = !key_s;
        repeat_d  = key_s && REPEAT_EN && (cnt_q == REP_LAST);
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
  end

  assign press_pulse   = press_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign release_pulse = release_q;
  assign held          = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: DUT A (LONG=8, REPEAT=4) and DUT B
// (LONG=8, REPEAT=0) share one key stimulus; pulse cycles are logged and compared.
module tb_key_event_gen;

`ifdef KEY_EVENT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;

  logic a_press, a_click, a_long, a_rep, a_rel, a_held;
  logic b_press, b_click, b_long, b_rep, b_rel, b_held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int qa_press[$], qa_click[$], qa_long[$], qa_rep[$], qa_rel[$];
  int qb_press[$], qb_click[$], qb_long[$], qb_rep[$], qb_rel[$];

  always #5 clk = ~clk;

  key_event_gen #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .press_pulse(a_press), .click_pulse(a_click), .long_pulse(a_long),
    .repeat_pulse(a_rep), .release_pulse(a_rel), .held(a_held)
  );

  key_event_gen #(.LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .press_pulse(b_press), .click_pulse(b_click), .long_pulse(b_long),
    .repeat_pulse(b_rep), .release_pulse(b_rel), .held(b_held)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    qa_press.delete(); qa_click.delete(); qa_long.delete(); qa_rep.delete(); qa_rel.delete();
    qb_press.delete(); qb_click.delete(); qb_long.delete(); qb_rep.delete(); qb_rel.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    key_in = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    clear_logs();
  endtask

  // Drive one cycle of key level, then log any pulse seen after that edge
  task automatic step(input logic k);
    key_in = k;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (a_press) qa_press.push_back(cyc);
    if (a_click) qa_click.push_back(cyc);
    if (a_long)  qa_long.push_back(cyc);
    if (a_rep)   qa_rep.push_back(cyc);
    if (a_rel)   qa_rel.push_back(cyc);
    if (b_press) qb_press.push_back(cyc);
    if (b_click) qb_click.push_back(cyc);
    if (b_long)  qb_long.push_back(cyc);
    if (b_rep)   qb_rep.push_back(cyc);
    if (b_rel)   qb_rel.push_back(cyc);
  endtask

  function automatic int all_outs();
    return int'({a_press, a_click, a_long, a_rep, a_rel, a_held,
                 b_press, b_click, b_long, b_rep, b_rel, b_held});
  endfunction

  initial begin
    #1;
    check_eq("reset_outputs", all_outs(), 0);

    // Short click: high 3 cycles
    do_reset();
    repeat (3) step(1'b1);
    repeat (7) step(1'b0);
    check_eq("s1_press_n", qa_press.size(), 1);
    check_eq("s1_press_t", qa_press[0], 1 + L);
    check_eq("s1_click_n", qa_click.size(), 1);
    check_eq("s1_click_t", qa_click[0], 4 + L);
    check_eq("s1_rel_t", qa_rel[0], 4 + L);
    check_eq("s1_long_n", qa_long.size(), 0);

    // Long hold 30 cycles with auto-repeat (A) and without (B)
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      if (i == 20) check_eq("s2_held_mid", int'(a_held), 1);
    end
    repeat (10) step(1'b0);
    check_eq("s2_press_t", qa_press[0], 1 + L);
    check_eq("s2_long_n", qa_long.size(), 1);
    check_eq("s2_long_t", qa_long[0], 9 + L);
    check_eq("s2_rep_n", qa_rep.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("s2_rep%0d_t", i), qa_rep[i], 13 + 4 * i + L);
    check_eq("s2_rel_n", qa_rel.size(), 1);
    check_eq("s2_rel_t", qa_rel[0], 31 + L);
    check_eq("s2_click_n", qa_click.size(), 0);
    check_eq("s2_held_end", int'(a_held), 0);
    check_eq("s3_long_t", qb_long[0], 9 + L);
    check_eq("s3_rep_n", qb_rep.size(), 0);
    check_eq("s3_rel_t", qb_rel[0], 31 + L);
    check_eq("s3_click_n", qb_click.size(), 0);

    // Release on the long-terminal edge
    do_reset();
    repeat (8) step(1'b1);
    repeat (6) step(1'b0);
    check_eq("s4a_long_n", qa_long.size(), 0);
    check_eq("s4a_click_t", qa_click[0], 9 + L);
    check_eq("s4a_rel_t", qa_rel[0], 9 + L);

    // Release on the repeat-terminal edge
    do_reset();
    repeat (12) step(1'b1);
    repeat (6) step(1'b0);
    check_eq("s4b_long_t", qa_long[0], 9 + L);
    check_eq("s4b_rep_n", qa_rep.size(), 0);
    check_eq("s4b_click_n", qa_click.size(), 0);
    check_eq("s4b_rel_t", qa_rel[0], 13 + L);

    // Single-cycle key pulse
    do_reset();
    step(1'b1);
    repeat (5) step(1'b0);
    check_eq("s5_press_t", qa_press[0], 1 + L);
    check_eq("s5_click_t", qa_click[0], 2 + L);
    check_eq("s5_rel_t", qa_rel[0], 2 + L);
    check_eq("s5_press_n", qa_press.size(), 1);

    // Reset mid-hold, key still pressed afterwards
    do_reset();
    repeat (10) step(1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_outs", all_outs(), 0);
    check_eq("s6_rel_before", qa_rel.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("s6_rst_hold", all_outs(), 0);
    rst_n = 1'b1;
    clear_logs();
    repeat (5) step(1'b1);
    check_eq("s6_press_t", qa_press[0], 1 + L);
    check_eq("s6_press_n", qa_press.size(), 1);
    check_eq("s6_rel_n", qa_rel.size(), 0);
    check_eq("s6_held", int'(a_held), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
